mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage pipeline.
- Grants one requester at a time and sequences the memory handshake. Returns read data to the granted requester.
- Produces per-requester stall signals; the pipeline control merges these with the load-use/branch stall and flush outputs of the hazard unit.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- STARVE_MAX, 4, consecutive data grants allowed while IF waits (used only with the optional feature).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF wants an instruction word; held until if_done
- if_addr  in  ADDR_W  fetch address (PC)
- d_read  in  1  MEM-stage load request; held until d_done
- d_write  in  1  MEM-stage store request; held until d_done
- d_addr  in  ADDR_W  load/store address
- d_wdata  in  DATA_W  store data
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- d_done  out  1  one-cycle pulse: load/store complete
- d_rdata  out  DATA_W  load data
- stall_if  out  1  if_req & ~if_done
- stall_mem  out  1  (d_read|d_write) & ~d_done
- ram_en  out  1  one-cycle memory command strobe
- ram_we  out  1  write qualifier, valid with ram_en
- ram_addr  out  ADDR_W  memory address, held from ISSUE through WAIT
- ram_wdata  out  DATA_W  write data, held from ISSUE through WAIT
- ram_ack  in  1  memory completion pulse; earliest in the ISSUE cycle
- ram_rdata  in  DATA_W  read data, valid with ram_ack

Behaviour:
- Reset: FSM=IDLE. ram_en, ram_we, if_done and d_done are 0. ram_addr, ram_wdata, if_rdata and d_rdata are 0. grant_is_data=0; starve counter=0.
- Reset mid-transaction aborts it: no done pulse is produced, and a late ram_ack is ignored.
- FSM states are IDLE, ISSUE, WAIT and RESP. All outputs are registered except stall_if and stall_mem.
- IDLE: evaluate requests each cycle.
  - If d_read or d_write is high, grant data.
  - Otherwise, if if_req is high, grant IF.
  - Otherwise stay in IDLE.
  - On grant: latch the address, write data, we (=d_write) and grant_is_data, then go to ISSUE.
- Data has fixed priority over IF, because the data request belongs to the older instruction.
- d_read and d_write both high is treated as a write.
- ISSUE: ram_en=1 for exactly this cycle. If ram_ack, go to RESP; otherwise go to WAIT.
- WAIT: ram_en=0, address and data held. Stay until ram_ack, then go to RESP.
- RESP: pulse the granted requester's done for one cycle; the other done stays 0.
  - For a read, capture ram_rdata (sampled on the ack cycle) into if_rdata or d_rdata.
  - For a store, d_rdata keeps its value.
  - Next state is always IDLE. Requests are not sampled in RESP, so the requester can drop its req on the cycle after done.
- Minimum latency: request seen in IDLE at cycle T, ISSUE at T+1 with ack at T+1, done at T+2, IDLE at T+3.
- ram_ack received in IDLE or RESP is ignored.
- The rdata registers hold their value until the next completion of the same requester type.
- Requests that change while a transaction is in flight have no effect until the next IDLE.
- stall_* are combinational so the pipeline freezes in the same cycle the request is raised.

Optional Feature:
- MEMARB_STARVE_GUARD_EN defined:
  - A counter increments on each data grant made while if_req=1. It clears on an IF grant or when if_req=0.
  - When the counter equals STARVE_MAX and if_req=1, the next IDLE grant goes to IF even if a data request is pending. The counter then clears.
  - The counter saturates at STARVE_MAX.
- Undefined: pure fixed data priority; the counter logic is absent.

Test Plan:
- Reset, then if_req=1, if_addr=0x0040_0000, ram_ack one cycle after ram_en, ram_rdata=0x2008_0005 -> ram_en=1 with ram_we=0 and ram_addr=0x0040_0000; if_done pulses once with if_rdata=0x2008_0005; stall_if=1 until the done cycle.
- if_req and d_read asserted together (d_addr=0x1001_0000) -> data granted first and d_done pulses. IF is then granted; if_done arrives after d_done.
- Store d_write=1, d_addr=0x1001_0004, d_wdata=0xDEAD_BEEF, ack after 3 WAIT cycles -> ram_we=1 with ram_en for 1 cycle; addr and data held 4 cycles; d_done pulses and d_rdata is unchanged.
- Zero-wait memory (ram_ack in the ISSUE cycle) -> done at T+2, IDLE at T+3; back-to-back IF requests are granted every 3 cycles.
- reset asserted during WAIT, then a stray ram_ack -> no done pulse, FSM in IDLE, ram_en=0.
- With MEMARB_STARVE_GUARD_EN and STARVE_MAX=4: continuous d_read plus if_req -> after the 4th data grant, IF is granted. Without the macro, IF is never granted while d_read stays high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the IF stage and
// the MEM stage. Data requests win over fetches. Each transaction runs
// IDLE -> ISSUE -> (WAIT)* -> RESP, with a one-cycle done pulse in RESP.
// Optional starvation guard: define MEMARB_STARVE_GUARD_EN so that after
// STARVE_MAX consecutive data grants made while IF waits, the next grant
// goes to IF.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state;
  logic   grant_is_data;
  logic   d_any;
  logic   grant_data;
  logic   grant_if;

  // a load and a store raised together are served as a store
  assign d_any = d_read | d_write;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_if;

  assign force_if   = if_req & (starve_cnt == STARVE_LIM);
  assign grant_data = d_any & ~force_if;

  // count data grants that overtook a waiting fetch; saturates at the limit
  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= '0;
    else if (!if_req)
      starve_cnt <= '0;
    else if (state == IDLE) begin
      if (grant_if)
        starve_cnt <= '0;
      else if (grant_data && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // data belongs to the older instruction, so it always goes first
  assign grant_data = d_any;
`endif

  assign grant_if = if_req & ~grant_data;

  // stalls are combinational so the pipeline freezes the cycle a request rises
  assign stall_if  = if_req & ~if_done;
  assign stall_mem = d_any & ~d_done;

  // transaction sequencer; every memory-side and done output is registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant_is_data <= 1'b0;
      ram_en        <= 1'b0;
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      if_done       <= 1'b0;
      d_done        <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
    end else begin
      ram_en  <= 1'b0;
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data || grant_if) begin
            grant_is_data <= grant_data;
            ram_addr      <= grant_data ? d_addr : if_addr;
            ram_wdata     <= grant_data ? d_wdata : '0;
            ram_we        <= grant_data & d_write;
            ram_en        <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          // address and data stay put until the memory acknowledges
          if (ram_ack) begin
            state <= RESP;
            if (grant_is_data) begin
              d_done <= 1'b1;
              if (!ram_we)
                d_rdata <= ram_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end else begin
            state <= WAIT;
          end
        end
        RESP: begin
          // requests are not sampled here, so requesters may drop req now
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a random
// run against a transaction-level reference model and a behavioural memory.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
`ifdef MEMARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [31:0] HASH = 32'h5A5A_A5A5;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          d_read, d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_done, d_done;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          stall_if, stall_mem;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ack;
  logic [DW-1:0] ram_rdata;

  int checks   = 0;
  int failures = 0;

  int ack_delay  = 1;
  bit rand_delay = 1'b0;
  bit stray_ack  = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .if_done(if_done), .if_rdata(if_rdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata)
  );

  // behavioural memory: acks a command after a programmable delay
  logic [DW-1:0] mem [logic [AW-1:0]];

  initial begin : responder
    bit pend;
    int left;
    pend = 1'b0;
    left = 0;
    ram_ack = 1'b0;
    ram_rdata = '0;
    mem[32'h0040_0000] = 32'h2008_0005;
    forever begin
      @(posedge clk); #1;
      ram_ack = 1'b0;
      if (reset) pend = 1'b0;
      else if (ram_en) begin
        pend = 1'b1;
        left = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
      end
      if (stray_ack) begin
        ram_ack = 1'b1;
        ram_rdata = 32'hBAD0_BAD0;
      end else if (pend) begin
        if (left == 0) begin
          pend = 1'b0;
          ram_ack = 1'b1;
          if (ram_we) begin
            mem[ram_addr] = ram_wdata;
            ram_rdata = $urandom;
          end else begin
            ram_rdata = mem.exists(ram_addr) ? mem[ram_addr] : (ram_addr ^ HASH);
          end
        end else begin
          left--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    tick(); tick();
    checks++;
    if ({ram_en, ram_we, if_done, d_done, stall_if, stall_mem} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctl got %b want 000000",
               {ram_en, ram_we, if_done, d_done, stall_if, stall_mem});
    end
    checks++;
    if ({ram_addr, ram_wdata} !== 64'h0) begin
      failures++; $display("FAIL reset_ram got %h %h want 0 0", ram_addr, ram_wdata);
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      failures++; $display("FAIL reset_rdata got %h %h want 0 0", if_rdata, d_rdata);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_if_fetch();
    int n_en, en_at, n_done, done_at;
    n_en = 0; en_at = -1; n_done = 0; done_at = -1;
    rand_delay = 1'b0; ack_delay = 1;
    if_req = 1'b1; if_addr = 32'h0040_0000;
    #1;
    checks++;
    if (stall_if !== 1'b1) begin
      failures++; $display("FAIL fetch_stall_rise got %b want 1", stall_if);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 3) begin
        checks++;
        if (stall_if !== (c < 3)) begin
          failures++; $display("FAIL fetch_stall c=%0d got %b want %b", c, stall_if, c < 3);
        end
      end
      if (ram_en) begin
        n_en++; en_at = c;
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 32'h0040_0000) begin
          failures++; $display("FAIL fetch_cmd got we=%b addr=%h want we=0 addr=00400000", ram_we, ram_addr);
        end
      end
      if (d_done) begin
        failures++; $display("FAIL fetch_ddone got 1 want 0 at c=%0d", c);
      end
      if (if_done) begin
        n_done++; done_at = c;
        checks++;
        if (if_rdata !== 32'h2008_0005) begin
          failures++; $display("FAIL fetch_rdata got %h want 20080005", if_rdata);
        end
        if_req = 1'b0;
      end
    end
    checks++;
    if (n_en != 1 || en_at != 1) begin
      failures++; $display("FAIL fetch_en got n=%0d at=%0d want n=1 at=1", n_en, en_at);
    end
    checks++;
    if (n_done != 1 || done_at != 3) begin
      failures++; $display("FAIL fetch_done got n=%0d at=%0d want n=1 at=3", n_done, done_at);
    end
  endtask

  task automatic test_priority();
    int n_en, d_at, i_at;
    logic [31:0] a0, a1;
    n_en = 0; d_at = -1; i_at = -1; a0 = '0; a1 = '0;
    rand_delay = 1'b0; ack_delay = 0;
    if_req = 1'b1; if_addr = 32'h0040_0008;
    d_read = 1'b1; d_addr = 32'h1001_0000;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ram_en) begin
        if (n_en == 0) a0 = ram_addr; else a1 = ram_addr;
        n_en++;
      end
      if (d_done) begin
        d_at = c; d_read = 1'b0;
        checks++;
        if (d_rdata !== (32'h1001_0000 ^ HASH)) begin
          failures++; $display("FAIL prio_drdata got %h want %h", d_rdata, 32'h1001_0000 ^ HASH);
        end
      end
      if (if_done) begin
        i_at = c; if_req = 1'b0;
        checks++;
        if (if_rdata !== (32'h0040_0008 ^ HASH)) begin
          failures++; $display("FAIL prio_irdata got %h want %h", if_rdata, 32'h0040_0008 ^ HASH);
        end
      end
    end
    checks++;
    if (n_en != 2 || a0 !== 32'h1001_0000 || a1 !== 32'h0040_0008) begin
      failures++; $display("FAIL prio_order got n=%0d %h,%h want n=2 10010000,00400008", n_en, a0, a1);
    end
    checks++;
    if (d_at != 2 || i_at != 5) begin
      failures++; $display("FAIL prio_done got d=%0d i=%0d want d=2 i=5", d_at, i_at);
    end
  endtask

  task automatic test_store_wait();
    int n_en, done_at;
    n_en = 0; done_at = -1;
    rand_delay = 1'b0; ack_delay = 3;
    d_write = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ram_en) begin
        n_en++;
        checks++;
        if (ram_we !== 1'b1 || c != 1) begin
          failures++; $display("FAIL store_en got we=%b c=%0d want we=1 c=1", ram_we, c);
        end
      end
      if (c <= 4) begin
        checks++;
        if (ram_addr !== 32'h1001_0004 || ram_wdata !== 32'hDEAD_BEEF) begin
          failures++; $display("FAIL store_hold c=%0d got %h %h want 10010004 deadbeef", c, ram_addr, ram_wdata);
        end
        checks++;
        if (stall_mem !== 1'b1) begin
          failures++; $display("FAIL store_stall c=%0d got %b want 1", c, stall_mem);
        end
      end
      if (d_done) begin
        done_at = c; d_write = 1'b0;
        checks++;
        if (d_rdata !== (32'h1001_0000 ^ HASH)) begin
          failures++; $display("FAIL store_drdata got %h want %h", d_rdata, 32'h1001_0000 ^ HASH);
        end
      end
    end
    checks++;
    if (n_en != 1 || done_at != 5) begin
      failures++; $display("FAIL store_done got n_en=%0d done=%0d want 1 5", n_en, done_at);
    end
  endtask

  task automatic test_zero_wait_b2b();
    int n_en, n_done;
    logic [31:0] a;
    n_en = 0; n_done = 0;
    rand_delay = 1'b0; ack_delay = 0;
    a = 32'h0040_0100;
    if_req = 1'b1; if_addr = a;
    for (int c = 1; c <= 13; c++) begin
      tick();
      checks++;
      if (ram_en !== (c % 3 == 1 && c <= 10)) begin
        failures++; $display("FAIL b2b_en c=%0d got %b want %b", c, ram_en, c % 3 == 1 && c <= 10);
      end
      if (ram_en) begin
        checks++;
        if (ram_addr !== 32'h0040_0100 + 32'(4 * n_en)) begin
          failures++; $display("FAIL b2b_addr got %h want %h", ram_addr, 32'h0040_0100 + 32'(4 * n_en));
        end
        n_en++;
      end
      checks++;
      if (if_done !== (c % 3 == 2 && c <= 11)) begin
        failures++; $display("FAIL b2b_done c=%0d got %b", c, if_done);
      end
      if (if_done) begin
        checks++;
        if (if_rdata !== (if_addr ^ HASH)) begin
          failures++; $display("FAIL b2b_rdata got %h want %h", if_rdata, if_addr ^ HASH);
        end
        n_done++;
        if (n_done < 4) begin a = a + 32'd4; if_addr = a; end
        else if_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    rand_delay = 1'b0; ack_delay = 10;
    d_read = 1'b1; d_addr = 32'h1001_0008;
    tick();
    checks++;
    if (ram_en !== 1'b1) begin
      failures++; $display("FAIL rmid_issue got %b want 1", ram_en);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; d_read = 1'b0; stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if ({ram_en, if_done, d_done} !== 3'b000 || d_rdata !== 32'h0) begin
        failures++; $display("FAIL rmid_quiet c=%0d got en/ifd/dd=%b d_rdata=%h want 000 0",
                             c, {ram_en, if_done, d_done}, d_rdata);
      end
    end
  endtask

  task automatic test_starve();
    int n_g, n_ifd;
    bit is_data [7];
    n_g = 0; n_ifd = 0;
    rand_delay = 1'b0; ack_delay = 0;
    d_read = 1'b1; d_addr = 32'h1001_0010;
    if_req = 1'b1; if_addr = 32'h0040_0020;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (ram_en && n_g < 7) begin
        is_data[n_g] = (ram_addr == 32'h1001_0010);
        n_g++;
      end
      if (if_done) begin n_ifd++; if_req = 1'b0; end
    end
    d_read = 1'b0; if_req = 1'b0;
    checks++;
    if (n_g != 7) begin
      failures++; $display("FAIL starve_grants got %0d want 7", n_g);
    end
    for (int i = 0; i < n_g; i++) begin
      checks++;
      if (is_data[i] !== !(GUARD && i == 4)) begin
        failures++; $display("FAIL starve_grant%0d got data=%b want %b", i, is_data[i], !(GUARD && i == 4));
      end
    end
    checks++;
    if (n_ifd != (GUARD ? 1 : 0)) begin
      failures++; $display("FAIL starve_ifdone got %0d want %0d", n_ifd, GUARD ? 1 : 0);
    end
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_random();
    bit s_if, s_rd, s_wr, g_data, g_we, frc, ack_prev, e_en, e_ifd, e_dd;
    logic [31:0] s_ifa, s_da, s_dw, g_addr, g_wd, ack_data, exp_ifr, exp_dr;
    int phase, cnt, kind;
    reset = 1'b1; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0; rand_delay = 1'b1;
    tick(); tick();
    reset = 1'b0;
    s_if = 0; s_rd = 0; s_wr = 0; s_ifa = '0; s_da = '0; s_dw = '0;
    g_data = 0; g_we = 0; g_addr = '0; g_wd = '0; ack_prev = 0; ack_data = '0;
    exp_ifr = '0; exp_dr = '0; phase = 0; cnt = 0;
    for (int c = 0; c < 700; c++) begin
      tick();
      e_en = 0; e_ifd = 0; e_dd = 0;
      // phase 0: arbiter free; 1: transaction open; 2: done just delivered
      if (phase == 0 && (s_if || s_rd || s_wr)) begin
        frc    = GUARD && s_if && cnt == SMAX;
        g_data = (s_rd || s_wr) && !frc;
        g_addr = g_data ? s_da : s_ifa;
        g_we   = g_data && s_wr;
        g_wd   = s_dw;
        e_en = 1; phase = 1;
        if (!g_data) cnt = 0;
        else if (s_if && cnt < SMAX) cnt++;
      end else if (phase == 1 && ack_prev) begin
        if (g_data) begin e_dd = 1; if (!g_we) exp_dr = ack_data; end
        else begin e_ifd = 1; exp_ifr = ack_data; end
        phase = 2;
      end else if (phase == 2) begin
        phase = 0;
      end
      if (!s_if) cnt = 0;

      checks++;
      if ({ram_en, if_done, d_done} !== {e_en, e_ifd, e_dd}) begin
        failures++; $display("FAIL rnd_ctl c=%0d got %b want %b", c, {ram_en, if_done, d_done}, {e_en, e_ifd, e_dd});
      end
      checks++;
      if ({if_rdata, d_rdata} !== {exp_ifr, exp_dr}) begin
        failures++; $display("FAIL rnd_rdata c=%0d got %h %h want %h %h", c, if_rdata, d_rdata, exp_ifr, exp_dr);
      end
      checks++;
      if ({stall_if, stall_mem} !== {s_if && !e_ifd, (s_rd || s_wr) && !e_dd}) begin
        failures++; $display("FAIL rnd_stall c=%0d got %b%b", c, stall_if, stall_mem);
      end
      if (phase == 1) begin
        checks++;
        if (ram_addr !== g_addr || ram_we !== g_we || (g_we && ram_wdata !== g_wd)) begin
          failures++; $display("FAIL rnd_cmd c=%0d got %h we=%b %h want %h we=%b %h",
                               c, ram_addr, ram_we, ram_wdata, g_addr, g_we, g_wd);
        end
      end

      ack_prev = ram_ack; ack_data = ram_rdata;
      if (if_done) if_req = 1'b0;
      if (d_done) begin d_read = 1'b0; d_write = 1'b0; end
      if (c < 600) begin
        if (!if_req && $urandom_range(0, 2) == 0) begin
          if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
          kind = int'($urandom_range(0, 3));
          d_read = (kind != 2); d_write = (kind >= 2);
          d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
        end
      end
      s_if = if_req; s_rd = d_read; s_wr = d_write;
      s_ifa = if_addr; s_da = d_addr; s_dw = d_wdata;
    end
    checks++;
    if (if_req || d_read || d_write || phase != 0) begin
      failures++; $display("FAIL rnd_drain got pending=%b%b%b phase=%0d want 000 0", if_req, d_read, d_write, phase);
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_priority();
    test_store_wait();
    test_zero_wait_b2b();
    test_reset_mid();
    test_starve();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
